// File: rtl/bfp16_pkg.sv
// BFP16 shared types for the adder front end: operand format and alignment stage record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bfp16_pkg;

    localparam int SIZE_EXP = 8;
    localparam int SIZE_MAN = 7;
    localparam int SIZE_GRS = 3;
    localparam int SIZE_EXT = 1 + SIZE_MAN + SIZE_GRS;

    typedef struct packed {
        logic                sign;
        logic [SIZE_EXP-1:0] exp;
        logic [SIZE_MAN-1:0] man;
    } bfp16_t;

    // One record type serves both pipeline registers; after stage 2 man_small
    // holds the aligned value, before it the unshifted extended mantissa.
    typedef struct packed {
        logic                sign;
        logic                eff_sub;
        logic                swap;
        logic [SIZE_EXP-1:0] exp;
        logic [SIZE_EXP-1:0] diff;
        logic [SIZE_EXT-1:0] man_big;
        logic [SIZE_EXT-1:0] man_small;
    } align_stage_t;

endpackage

// File: rtl/shf_right_sticky.sv
// Right shift that ORs every shifted-out bit into the result LSB (sticky), saturating for large shifts.
// Latency: combinational.
// Backpressure: none (pure function).
//
// Ports: i_data   value to shift
//        i_shift  shift amount (unsigned)
//        o_data   shifted value, LSB = shifted LSB | any bit lost
module shf_right_sticky #(
    parameter int SIZE_DATA  = 11,
    parameter int SIZE_SHIFT = 8
) (
    input  logic [SIZE_DATA-1:0]  i_data,
    input  logic [SIZE_SHIFT-1:0] i_shift,
    output logic [SIZE_DATA-1:0]  o_data
);

    logic [SIZE_DATA-1:0] w_mask;
    logic [SIZE_DATA-1:0] w_shifted;
    logic                 w_lost;

    always_comb begin
        w_mask    = '0;
        w_shifted = '0;
        w_lost    = 1'b0;
        o_data    = '0;
        if (32'(i_shift) >= SIZE_DATA) begin
            // Everything falls off the end: only the sticky survives.
            o_data = {{(SIZE_DATA-1){1'b0}}, |i_data};
        end else begin
            w_shifted = i_data >> i_shift;
            // Mask selects exactly the i_shift low bits that are discarded.
            w_mask    = ~({SIZE_DATA{1'b1}} << i_shift);
            w_lost    = |(i_data & w_mask);
            o_data    = {w_shifted[SIZE_DATA-1:1], w_shifted[0] | w_lost};
        end
    end

endmodule

// File: rtl/bfp16_align_pipe.sv
// BFP16 pre-add alignment: order operands by magnitude, right-shift the smaller with guard/round/sticky.
// Latency: 2 cycles accept-to-valid, 1 transaction per cycle.
// Backpressure: valid/ready, o_ready combinational from i_ready (no skid); outputs hold while stalled.
//
// Ports: i_clk/i_rst_n           clock, async active-low reset
//        i_valid/o_ready         operand pair handshake; i_op_sub selects A-B
//        i_data_a/i_data_b       operands {sign, exp, man}
//        o_valid/i_ready         result handshake
//        o_exp/o_sign/o_eff_sub  larger exponent, result sign, effective subtraction
//        o_swap                  B was the larger magnitude
//        o_man_big/o_man_small   {hidden, man, grs}; small is aligned, LSB sticky
module bfp16_align_pipe
    import bfp16_pkg::*;
#(
    parameter int SIZE_EXP = bfp16_pkg::SIZE_EXP,
    parameter int SIZE_MAN = bfp16_pkg::SIZE_MAN,
    parameter int SIZE_GRS = bfp16_pkg::SIZE_GRS
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic                           i_op_sub,
    input  logic [SIZE_EXP+SIZE_MAN:0]     i_data_a,
    input  logic [SIZE_EXP+SIZE_MAN:0]     i_data_b,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [SIZE_EXP-1:0]            o_exp,
    output logic                           o_sign,
    output logic                           o_eff_sub,
    output logic                           o_swap,
    output logic [SIZE_MAN+SIZE_GRS:0]     o_man_big,
    output logic [SIZE_MAN+SIZE_GRS:0]     o_man_small
);

    localparam int SIZE_DATA = 1 + SIZE_EXP + SIZE_MAN;
    localparam int SIZE_EXT  = 1 + SIZE_MAN + SIZE_GRS;

    bfp16_t              w_a;
    bfp16_t              w_b;
    logic                w_hid_a;
    logic                w_hid_b;
    logic [SIZE_MAN-1:0] w_man_a;
    logic [SIZE_MAN-1:0] w_man_b;
    logic [SIZE_EXT-1:0] w_ext_a;
    logic [SIZE_EXT-1:0] w_ext_b;
    logic                w_swap;
    logic                w_adv1;
    logic                w_adv2;
    logic [SIZE_EXT-1:0] w_small_sh;
    align_stage_t        w_s1_next;
    align_stage_t        w_s2_next;

    align_stage_t        r_s1;
    align_stage_t        r_s2;
    logic                r_s1_valid;
    logic                r_s2_valid;

    // ---------------- operand decode ----------------
    assign w_a     = i_data_a;
    assign w_b     = i_data_b;
    assign w_hid_a = |w_a.exp;
    assign w_hid_b = |w_b.exp;
    // exp == 0 means zero: flush the mantissa so it cannot win a compare or leak into sticky.
    assign w_man_a = w_hid_a ? w_a.man : '0;
    assign w_man_b = w_hid_b ? w_b.man : '0;
    assign w_ext_a = {w_hid_a, w_man_a, {SIZE_GRS{1'b0}}};
    assign w_ext_b = {w_hid_b, w_man_b, {SIZE_GRS{1'b0}}};
    // Strict compare so equal magnitudes keep A as the big operand.
    assign w_swap  = {w_b.exp, w_man_b} > {w_a.exp, w_man_a};

    always_comb begin
        w_s1_next         = '0;
        w_s1_next.swap    = w_swap;
        w_s1_next.eff_sub = w_a.sign ^ w_b.sign ^ i_op_sub;
        if (w_swap) begin
            // B leads the result, so its sign carries the subtract.
            w_s1_next.sign      = w_b.sign ^ i_op_sub;
            w_s1_next.exp       = w_b.exp;
            w_s1_next.diff      = w_b.exp - w_a.exp;
            w_s1_next.man_big   = w_ext_b;
            w_s1_next.man_small = w_ext_a;
        end else begin
            w_s1_next.sign      = w_a.sign;
            w_s1_next.exp       = w_a.exp;
            w_s1_next.diff      = w_a.exp - w_b.exp;
            w_s1_next.man_big   = w_ext_a;
            w_s1_next.man_small = w_ext_b;
        end
    end

    // ---------------- stage 2 alignment ----------------
    shf_right_sticky #(
        .SIZE_DATA  (SIZE_EXT),
        .SIZE_SHIFT (SIZE_EXP)
    ) u_shf (
        .i_data  (r_s1.man_small),
        .i_shift (r_s1.diff),
        .o_data  (w_small_sh)
    );

    always_comb begin
        w_s2_next           = r_s1;
        w_s2_next.man_small = w_small_sh;
    end

    // ---------------- handshake ----------------
    assign w_adv2  = ~r_s2_valid | i_ready;
    assign w_adv1  = ~r_s1_valid | w_adv2;
    assign o_ready = w_adv1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1 <= w_s1_next;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2 <= w_s2_next;
            end
        end
    end

    assign o_valid     = r_s2_valid;
    assign o_exp       = r_s2.exp;
    assign o_sign      = r_s2.sign;
    assign o_eff_sub   = r_s2.eff_sub;
    assign o_swap      = r_s2.swap;
    assign o_man_big   = r_s2.man_big;
    assign o_man_small = r_s2.man_small;

endmodule

// File: tb/tb_bfp16_align_pipe.sv
// Directed bench for bfp16_align_pipe: hand-computed vectors, latency, streaming, stall and reset.
// Latency: n/a.
// Backpressure: exercised by holding i_ready low during a streamed burst.
module tb_bfp16_align_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic        op_sub;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic        out_vld;
    logic        out_rdy;
    logic [7:0]  o_exp;
    logic        o_sign;
    logic        o_eff_sub;
    logic        o_swap;
    logic [10:0] o_man_big;
    logic [10:0] o_man_small;

    int checks   = 0;
    int failures = 0;

    localparam int NV = 9;
    logic [15:0] va [NV];
    logic [15:0] vb [NV];
    logic        vs [NV];
    logic [32:0] ve [NV];

    bfp16_align_pipe dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (in_vld),
        .o_ready     (in_rdy),
        .i_op_sub    (op_sub),
        .i_data_a    (data_a),
        .i_data_b    (data_b),
        .o_valid     (out_vld),
        .i_ready     (out_rdy),
        .o_exp       (o_exp),
        .o_sign      (o_sign),
        .o_eff_sub   (o_eff_sub),
        .o_swap      (o_swap),
        .o_man_big   (o_man_big),
        .o_man_small (o_man_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [32:0] mk(input logic [7:0] e, input logic s, input logic es,
                                       input logic sw, input logic [10:0] big, input logic [10:0] sml);
        return {e, s, es, sw, big, sml};
    endfunction

    function automatic logic [32:0] outs();
        return {o_exp, o_sign, o_eff_sub, o_swap, o_man_big, o_man_small};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int i);
        data_a = va[i];
        data_b = vb[i];
        op_sub = vs[i];
    endtask

    // Streams n vectors starting at base; i_ready is low for cycles < rdy_on.
    // Called at a negedge; returns at a negedge.
    task automatic run_stream(input int base, input int n, input int rdy_on, input bit bp_check,
                              input string tag);
        int          q[$];
        int          sent = 0;
        int          got  = 0;
        bit          prev_stall = 0;
        logic [32:0] prev_outs  = '0;
        for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
            out_rdy = (cyc >= rdy_on);
            in_vld  = (sent < n);
            if (sent < n) drive(base + sent);
            #1;
            if (prev_stall) begin
                chk({tag, "_hold_vld"}, 64'(out_vld), 64'(1));
                chk({tag, "_hold_dat"}, 64'(outs()), 64'(prev_outs));
            end
            if (bp_check && cyc == 2) begin
                chk({tag, "_rdy_low"}, 64'(in_rdy), 64'(0));
                chk({tag, "_accepts"}, 64'(sent), 64'(2));
            end
            if (rdy_on == 0) chk({tag, "_rdy"}, 64'(in_rdy), 64'(1));
            if (out_vld && out_rdy) begin
                if (q.size() == 0) begin
                    chk({tag, "_spurious"}, 64'(1), 64'(0));
                end else begin
                    chk({tag, "_dat"}, 64'(outs()), 64'(ve[q.pop_front()]));
                end
                got++;
            end
            if (in_vld && in_rdy) begin
                q.push_back(base + sent);
                sent++;
            end
            prev_stall = out_vld && !out_rdy;
            prev_outs  = outs();
            @(posedge clk);
            @(negedge clk);
        end
        in_vld = 1'b0;
        chk({tag, "_count"}, 64'(got), 64'(n));
        chk({tag, "_left"}, 64'(q.size()), 64'(0));
    endtask

    initial begin
        va[0] = 16'h3F80; vb[0] = 16'h4000; vs[0] = 1'b0; ve[0] = mk(8'h80, 0, 0, 1, 11'h400, 11'h200);
        va[1] = 16'h3F80; vb[1] = 16'h3FC0; vs[1] = 1'b1; ve[1] = mk(8'h7F, 1, 1, 1, 11'h600, 11'h400);
        va[2] = 16'h4B80; vb[2] = 16'h3F80; vs[2] = 1'b0; ve[2] = mk(8'h97, 0, 0, 0, 11'h400, 11'h001);
        va[3] = 16'h0000; vb[3] = 16'h3F80; vs[3] = 1'b0; ve[3] = mk(8'h7F, 0, 0, 1, 11'h400, 11'h000);
        va[4] = 16'hC380; vb[4] = 16'h3FC1; vs[4] = 1'b1; ve[4] = mk(8'h87, 1, 0, 0, 11'h400, 11'h007);
        va[5] = 16'h3F80; vb[5] = 16'hC000; vs[5] = 1'b1; ve[5] = mk(8'h80, 0, 0, 1, 11'h400, 11'h200);
        va[6] = 16'h4000; vb[6] = 16'h4000; vs[6] = 1'b1; ve[6] = mk(8'h80, 0, 1, 0, 11'h400, 11'h400);
        va[7] = 16'h0000; vb[7] = 16'h8000; vs[7] = 1'b0; ve[7] = mk(8'h00, 0, 1, 0, 11'h000, 11'h000);
        va[8] = 16'h7F80; vb[8] = 16'h3F80; vs[8] = 1'b0; ve[8] = mk(8'hFF, 0, 0, 0, 11'h400, 11'h001);

        // Reset state
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        op_sub  = 1'b0;
        data_a  = '0;
        data_b  = '0;
        #1;
        chk("rst_vld", 64'(out_vld), 64'(0));
        chk("rst_rdy", 64'(in_rdy), 64'(1));
        chk("rst_dat", 64'(outs()), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single transactions: exact two-cycle latency and per-vector values
        for (int i = 0; i < NV; i++) begin
            in_vld  = 1'b1;
            out_rdy = 1'b1;
            drive(i);
            #1;
            chk("lat_rdy", 64'(in_rdy), 64'(1));
            @(posedge clk);
            @(negedge clk);
            in_vld = 1'b0;
            #1;
            chk("lat_c1", 64'(out_vld), 64'(0));
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("lat_c2", 64'(out_vld), 64'(1));
            chk($sformatf("vec%0d", i), 64'(outs()), 64'(ve[i]));
        end
        @(posedge clk);
        @(negedge clk);

        // Back-to-back at full throughput
        run_stream(0, NV, 0, 1'b0, "thru");

        // Backpressure: i_ready low for cycles 0..5 of a 4-pair burst
        run_stream(0, 4, 6, 1'b1, "bp");

        // Mid-stream reset with both stages full
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        drive(4);
        @(posedge clk);
        @(negedge clk);
        drive(5);
        @(posedge clk);
        @(negedge clk);
        in_vld = 1'b0;
        #1;
        chk("prerst_vld", 64'(out_vld), 64'(1));
        chk("prerst_rdy", 64'(in_rdy), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", 64'(out_vld), 64'(0));
        chk("mrst_dat", 64'(outs()), 64'(0));
        chk("mrst_rdy", 64'(in_rdy), 64'(1));
        @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("post_rst_idle", 64'(out_vld), 64'(0));
            @(posedge clk);
            @(negedge clk);
        end
        run_stream(6, 3, 0, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
